com_test_filter: RTL and testbench
==================================

COM_TEST_FILTER -- requirements
Module: com_test_filter

Interface
REQ-001 Parameter DIV, default 100: sample prescaler; one filter tick every DIV clocks; legal range 1..65535.
REQ-002 Parameter FILT, default 8: consecutive differing ticks needed to accept a feedback change; legal range 2..15.
REQ-003 Parameter MIS_T, default 50: ticks of command/feedback disagreement before a mismatch is flagged; legal range 1..255.
REQ-004 iClk  input  1  system clock; all state is clocked on its rising edge.
REQ-005 iRes  input  1  reset; asynchronous assertion, active-low.
REQ-006 iComFb  input  16  raw relay feedback contacts, active-low, asynchronous.
REQ-007 iCom  input  16  commanded outputs from the command stage, active-low, asynchronous.
REQ-008 iEnable  input  1  terminal-block enable from the command stage, active-low, asynchronous.
REQ-009 oComT  output  16  filtered feedback word, active-low; drives the command stage test input.
REQ-010 oMismatch  output  16  per-channel disagreement flag, active-high.
REQ-011 oFault  output  1  oValid AND (OR of oMismatch), registered.
REQ-012 oValid  output  1  filters settled since reset.

Function
REQ-013 iComFb, iCom and iEnable SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 The prescaler SHALL count 0..DIV-1, wrap to 0, and assert tick for exactly one clock when the count equals DIV-1; with DIV=1, tick is high every clock.
REQ-015 Per channel i, on each tick: if synced iComFb[i] differs from oComT[i], the counter increments; if equal, the counter clears.
REQ-016 When the increment would reach FILT, oComT[i] SHALL take the synced value on that tick and the counter SHALL clear; input-to-output latency is therefore 2 clocks plus FILT ticks.
REQ-017 A difference lasting fewer than FILT consecutive ticks SHALL leave oComT[i] unchanged.
REQ-018 Per channel, on each tick with synced iEnable=0 and oComT[i] differing from synced iCom[i], the mismatch counter SHALL increment, saturating at MIS_T.
REQ-019 oMismatch[i] SHALL be set on the tick the mismatch counter reaches MIS_T.
REQ-020 On any tick with agreement, or with synced iEnable=1, the mismatch counter and oMismatch[i] SHALL clear on that tick.
REQ-021 oValid SHALL set on the FILT-th tick after reset release and remain set until reset.
REQ-022 oFault SHALL be registered one clock after oMismatch and oValid.
REQ-023 Channels SHALL be independent; simultaneous changes on several channels are filtered in parallel with no priority.

Reset
REQ-024 While iRes=0: oComT=16'hFFFF, oMismatch=0, oFault=0, oValid=0, and the prescaler, all counters and all synchronizer flops (set to inactive-high) are cleared, asynchronously.
REQ-025 Reset asserted mid-count SHALL discard all partial counts; after release, filtering restarts from prescaler count 0.

Structure
REQ-026 Shared package bsk_prm_pkg SHALL hold COM_WIDTH=16, COM_IDLE=16'hFFFF and the default DIV/FILT/MIS_T values.
REQ-027 One sub-module, com_filter_ch (debounce counter plus mismatch timer for one bit), SHALL be instantiated COM_WIDTH times; the prescaler, synchronizers and oValid logic stay at top level.

Verification (DIV=4, FILT=3, MIS_T=5)
REQ-028 Reset release -> oComT=FFFF, oValid=0; oValid=1 on the 3rd tick (clock 12 after release).
REQ-029 iComFb=FFFE held -> oComT=FFFE on the 3rd tick after the synced change; all other bits stay 1.
REQ-030 iComFb[5]=0 for 2 ticks, then back to 1 -> oComT stays FFFF; the channel 5 counter returns to 0.
REQ-031 iEnable=0, iCom=FFFE, iComFb=FFFF -> oMismatch=0001 on the 5th tick; oFault=1 one clock later; then iEnable=1 -> oMismatch=0 on the next tick and oFault=0 one clock later.
REQ-032 iRes=0 while the channel 0 counter is 2 -> all outputs return to reset values immediately; after release, a change needs a full 3 ticks again.
REQ-033 DIV=1, FILT=2: iComFb=0000 held -> oComT=0000 four clocks after the input change (2 sync + 2 ticks).

Source files
------------

// File: rtl/bsk_prm_pkg.sv
// Shared parameters for the relay command/feedback path.
//   COM_WIDTH   - number of relay channels
//   COM_IDLE    - inactive (all-off, active-low) command/feedback word
//   *_DEF       - default prescaler, debounce and mismatch-timer settings
package bsk_prm_pkg;
  localparam int          COM_WIDTH = 16;
  localparam logic [15:0] COM_IDLE  = 16'hFFFF;
  localparam int          DIV_DEF   = 100;
  localparam int          FILT_DEF  = 8;
  localparam int          MIS_T_DEF = 50;

  typedef logic [COM_WIDTH-1:0] com_word_t;
endpackage

// File: rtl/com_filter_ch.sv
// One relay channel: feedback debounce plus command/feedback mismatch timer.
//   clk, rst_n  - clock, async active-low reset
//   tick        - filter sample strobe
//   fb          - synchronized raw feedback bit (active-low)
//   com         - synchronized command bit (active-low)
//   en_n        - synchronized terminal-block enable (active-low)
//   comt        - debounced feedback bit (active-low)
//   mis         - mismatch flag (active-high)
module com_filter_ch #(
  parameter int FILT  = 8,
  parameter int MIS_T = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic fb,
  input  logic com,
  input  logic en_n,
  output logic comt,
  output logic mis
);
  localparam logic [3:0] FILT_M1 = 4'(FILT - 1);
  localparam logic [7:0] MIS_MAX = 8'(MIS_T);
  localparam logic [7:0] MIS_M1  = 8'(MIS_T - 1);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mcnt_q, mcnt_d;
  logic       comt_q, comt_d;
  logic       mis_q, mis_d;

  always_comb begin
    cnt_d  = cnt_q;
    comt_d = comt_q;
    mcnt_d = mcnt_q;
    mis_d  = mis_q;
    if (tick) begin
      // Debounce: a run of FILT differing ticks is needed to accept a change.
      if (fb != comt_q) begin
        if (cnt_q == FILT_M1) begin
          comt_d = fb;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
      // Mismatch timer compares against the debounced value held before this tick.
      if (!en_n && (comt_q != com)) begin
        if (mcnt_q != MIS_MAX) mcnt_d = mcnt_q + 8'd1;
        if (mcnt_q >= MIS_M1)  mis_d  = 1'b1;
      end else begin
        mcnt_d = '0;
        mis_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      comt_q <= 1'b1;
      mcnt_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      comt_q <= comt_d;
      mcnt_q <= mcnt_d;
      mis_q  <= mis_d;
    end
  end

  assign comt = comt_q;
  assign mis  = mis_q;
endmodule

// File: rtl/com_test_filter.sv
// Relay feedback filter: synchronizes and debounces the relay feedback
// contacts and flags channels whose filtered feedback disagrees with the
// command while the terminal block is enabled.
//   iClk, iRes  - clock, async active-low reset
//   iComFb     - raw feedback contacts (active-low, async)
//   iCom       - commanded outputs (active-low, async)
//   iEnable    - terminal-block enable (active-low, async)
//   oComT      - debounced feedback word (active-low)
//   oMismatch  - per-channel disagreement flags
//   oFault     - registered valid AND any mismatch
//   oValid     - filters settled since reset
module com_test_filter
  import bsk_prm_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int FILT  = FILT_DEF,
  parameter int MIS_T = MIS_T_DEF
) (
  input  logic                 iClk,
  input  logic                 iRes,
  input  logic [COM_WIDTH-1:0] iComFb,
  input  logic [COM_WIDTH-1:0] iCom,
  input  logic                 iEnable,
  output logic [COM_WIDTH-1:0] oComT,
  output logic [COM_WIDTH-1:0] oMismatch,
  output logic                 oFault,
  output logic                 oValid
);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [3:0]  FILT_M1 = 4'(FILT - 1);

  com_word_t   fb_s1_q, fb_s2_q, com_s1_q, com_s2_q;
  logic        en_s1_q, en_s2_q;
  logic [15:0] pre_q, pre_d;
  logic [3:0]  vcnt_q, vcnt_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        tick;

  // Two-flop synchronizers; reset to the inactive (high) level.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      fb_s1_q  <= COM_IDLE;
      fb_s2_q  <= COM_IDLE;
      com_s1_q <= COM_IDLE;
      com_s2_q <= COM_IDLE;
      en_s1_q  <= 1'b1;
      en_s2_q  <= 1'b1;
    end else begin
      fb_s1_q  <= iComFb;
      fb_s2_q  <= fb_s1_q;
      com_s1_q <= iCom;
      com_s2_q <= com_s1_q;
      en_s1_q  <= iEnable;
      en_s2_q  <= en_s1_q;
    end
  end

  assign tick = (pre_q == DIV_M1);

  always_comb begin
    pre_d   = tick ? 16'd0 : pre_q + 16'd1;
    vcnt_d  = vcnt_q;
    valid_d = valid_q;
    // oValid latches on the FILT-th tick: the first point a change could have passed.
    if (tick && !valid_q) begin
      if (vcnt_q == FILT_M1) valid_d = 1'b1;
      else                   vcnt_d  = vcnt_q + 4'd1;
    end
    fault_d = valid_q & (|oMismatch);
  end

  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      pre_q   <= '0;
      vcnt_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      vcnt_q  <= vcnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  for (genvar i = 0; i < COM_WIDTH; i++) begin : g_ch
    com_filter_ch #(.FILT(FILT), .MIS_T(MIS_T)) u_ch (
      .clk  (iClk),
      .rst_n(iRes),
      .tick (tick),
      .fb   (fb_s2_q[i]),
      .com  (com_s2_q[i]),
      .en_n (en_s2_q),
      .comt (oComT[i]),
      .mis  (oMismatch[i])
    );
  end

  assign oValid = valid_q;
  assign oFault = fault_q;
endmodule

// File: tb/tb_com_test_filter.sv
module tb_com_test_filter;
  logic        iClk = 1'b0;
  logic        iRes;
  logic [15:0] iComFb, iComFb1, iCom;
  logic        iEnable;
  logic [15:0] oComT, oMismatch, oComT1, oMismatch1;
  logic        oFault, oValid, oFault1, oValid1;
  int          vecs = 0;
  int          errs = 0;
  int          clk_n;

  always #5 iClk = ~iClk;

  // Main instance: DIV=4, FILT=3, MIS_T=5 -> ticks on edges 4,8,12,... after release.
  com_test_filter #(.DIV(4), .FILT(3), .MIS_T(5)) dut (
    .iClk(iClk), .iRes(iRes), .iComFb(iComFb), .iCom(iCom), .iEnable(iEnable),
    .oComT(oComT), .oMismatch(oMismatch), .oFault(oFault), .oValid(oValid));

  // Fast instance: DIV=1, FILT=2.
  com_test_filter #(.DIV(1), .FILT(2), .MIS_T(5)) dut1 (
    .iClk(iClk), .iRes(iRes), .iComFb(iComFb1), .iCom(iCom), .iEnable(iEnable),
    .oComT(oComT1), .oMismatch(oMismatch1), .oFault(oFault1), .oValid(oValid1));

  // Rising edges since reset release.
  always @(posedge iClk or negedge iRes)
    if (!iRes) clk_n <= 0;
    else       clk_n <= clk_n + 1;

  // Advance to the falling edge following rising edge n.
  task automatic wait_clk(input int n);
    int guard = 0;
    while (clk_n < n && guard < 2000) begin
      @(negedge iClk);
      guard++;
    end
    if (clk_n != n) begin
      errs++; vecs++;
      $display("FAIL wait_clk clk_n=%0d exp=%0d", clk_n, n);
    end
  endtask

  task automatic test_reset;
    iRes = 1'b0; iComFb = 16'hFFFF; iComFb1 = 16'hFFFF; iCom = 16'hFFFF; iEnable = 1'b1;
    repeat (3) @(negedge iClk);
    vecs++; if (oComT !== 16'hFFFF || oMismatch !== 16'h0 || oFault !== 1'b0 || oValid !== 1'b0) begin
      errs++; $display("FAIL rst_outputs comt=%h mis=%h flt=%b vld=%b exp FFFF/0000/0/0", oComT, oMismatch, oFault, oValid); end
    iRes = 1'b1;
    wait_clk(11);
    vecs++; if (oValid !== 1'b0) begin errs++; $display("FAIL valid_early got=%b exp=0", oValid); end
    wait_clk(12);
    vecs++; if (oValid !== 1'b1) begin errs++; $display("FAIL valid_set got=%b exp=1", oValid); end
    vecs++; if (oComT !== 16'hFFFF) begin errs++; $display("FAIL comt_idle got=%h exp=FFFF", oComT); end
  endtask

  task automatic test_filter;
    iComFb = 16'hFFFE;                 // synced by edge 14; ticks 16,20,24
    wait_clk(23);
    vecs++; if (oComT !== 16'hFFFF) begin errs++; $display("FAIL filt_hold got=%h exp=FFFF", oComT); end
    wait_clk(24);
    vecs++; if (oComT !== 16'hFFFE) begin errs++; $display("FAIL filt_set got=%h exp=FFFE", oComT); end
    iComFb = 16'hFFFF;                 // synced by 26; ticks 28,32,36
    wait_clk(35);
    vecs++; if (oComT !== 16'hFFFE) begin errs++; $display("FAIL filt_back_hold got=%h exp=FFFE", oComT); end
    wait_clk(36);
    vecs++; if (oComT !== 16'hFFFF) begin errs++; $display("FAIL filt_back got=%h exp=FFFF", oComT); end
  endtask

  task automatic test_glitch;
    iComFb = 16'hFFDF;                 // synced by 38; ticks 40,44
    wait_clk(44);
    vecs++; if (dut.g_ch[5].u_ch.cnt_q !== 4'd2) begin errs++; $display("FAIL glitch_cnt2 got=%0d exp=2", dut.g_ch[5].u_ch.cnt_q); end
    iComFb = 16'hFFFF;                 // back before tick 48
    wait_clk(48);
    vecs++; if (dut.g_ch[5].u_ch.cnt_q !== 4'd0) begin errs++; $display("FAIL glitch_cnt0 got=%0d exp=0", dut.g_ch[5].u_ch.cnt_q); end
    vecs++; if (oComT !== 16'hFFFF) begin errs++; $display("FAIL glitch_comt got=%h exp=FFFF", oComT); end
  endtask

  task automatic test_mismatch;
    iEnable = 1'b0; iCom = 16'hFFFE; iComFb = 16'hFFFF;  // synced by 50; ticks 52..68
    wait_clk(67);
    vecs++; if (oMismatch !== 16'h0000) begin errs++; $display("FAIL mis_early got=%h exp=0000", oMismatch); end
    wait_clk(68);
    vecs++; if (oMismatch !== 16'h0001) begin errs++; $display("FAIL mis_set got=%h exp=0001", oMismatch); end
    vecs++; if (oFault !== 1'b0) begin errs++; $display("FAIL fault_lag got=%b exp=0", oFault); end
    wait_clk(69);
    vecs++; if (oFault !== 1'b1) begin errs++; $display("FAIL fault_set got=%b exp=1", oFault); end
    iEnable = 1'b1;                    // synced by 71; tick 72 clears
    wait_clk(71);
    vecs++; if (oMismatch !== 16'h0001) begin errs++; $display("FAIL mis_hold got=%h exp=0001", oMismatch); end
    wait_clk(72);
    vecs++; if (oMismatch !== 16'h0000) begin errs++; $display("FAIL mis_clr got=%h exp=0000", oMismatch); end
    vecs++; if (oFault !== 1'b1) begin errs++; $display("FAIL fault_hold got=%b exp=1", oFault); end
    wait_clk(73);
    vecs++; if (oFault !== 1'b0) begin errs++; $display("FAIL fault_clr got=%b exp=0", oFault); end
  endtask

  task automatic test_reset_mid;
    iCom = 16'hFFFF; iComFb = 16'hFFFE;  // synced by 75; ticks 76,80
    wait_clk(80);
    vecs++; if (dut.g_ch[0].u_ch.cnt_q !== 4'd2) begin errs++; $display("FAIL mid_cnt2 got=%0d exp=2", dut.g_ch[0].u_ch.cnt_q); end
    iRes = 1'b0;
    #1;
    vecs++; if (oComT !== 16'hFFFF || oValid !== 1'b0 || oMismatch !== 16'h0 || oFault !== 1'b0) begin
      errs++; $display("FAIL mid_rst comt=%h vld=%b mis=%h flt=%b exp FFFF/0/0000/0", oComT, oValid, oMismatch, oFault); end
    vecs++; if (dut.g_ch[0].u_ch.cnt_q !== 4'd0) begin errs++; $display("FAIL mid_cnt0 got=%0d exp=0", dut.g_ch[0].u_ch.cnt_q); end
    repeat (2) @(negedge iClk);
    iRes = 1'b1;                       // iComFb still FFFE: synced by 2; ticks 4,8,12
    wait_clk(11);
    vecs++; if (oComT !== 16'hFFFF) begin errs++; $display("FAIL mid_hold got=%h exp=FFFF", oComT); end
    wait_clk(12);
    vecs++; if (oComT !== 16'hFFFE) begin errs++; $display("FAIL mid_full got=%h exp=FFFE", oComT); end
  endtask

  task automatic test_div1;
    iComFb1 = 16'h0000;                // edges 13,14 sync; ticks 15,16
    wait_clk(15);
    vecs++; if (oComT1 !== 16'hFFFF) begin errs++; $display("FAIL div1_hold got=%h exp=FFFF", oComT1); end
    wait_clk(16);
    vecs++; if (oComT1 !== 16'h0000) begin errs++; $display("FAIL div1_set got=%h exp=0000", oComT1); end
  endtask

  initial begin
    test_reset;
    test_filter;
    test_glitch;
    test_mismatch;
    test_reset_mid;
    test_div1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
